mips_lsu_bus: RTL and testbench
===============================

# mips_lsu_bus

Parametrised load/store unit that sits between the multicycle MIPS core's execute stage and the Avalon-MM data master. It accepts one memory request at a time, applies the MIPS load/store alignment rules, and drives a DATA_W-wide Avalon bus with the correct byte lanes. It returns sign- or zero-extended or merged (LWL/LWR) results, and reports misalignment and bus-timeout faults. Byte-lane order is little-endian.

## Interface
- DATA_W, 32: Avalon data width, 32 or 64; BYTES = DATA_W/8, OFS_W = log2(BYTES).
- ADDR_W, 32: byte address width.
- TIMEOUT, 0: maximum consecutive waitrequest-high cycles before abort; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  lsu_op_t: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rt).
- req_rt_old  in  32  current rt value, used for the LWL/LWR merge.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  2  lsu_fault_t: 00 OK, 01 MISALIGN, 10 TIMEOUT.
- address  out  ADDR_W  req_addr with the low OFS_W bits cleared.
- read, write  out  1  Avalon strobes.
- waitrequest  in  1  Avalon stall.
- writedata  out  DATA_W  replicated store data.
- byteenable  out  BYTES  active lanes.
- readdata  in  DATA_W  valid in the cycle in which read is high and waitrequest is low.

## Operation
- States: IDLE, BUS, RESP.
- The request, lane offset k = req_addr[OFS_W-1:0] and old rt value are captured on accept (req_valid && req_ready).
- Misalignment:
  - LH, LHU, SH fault when addr[0] = 1.
  - LW, SW fault when addr[1:0] ≠ 0.
  - LB, LBU, SB, LWL, LWR never fault.
  - A misaligned request goes IDLE→RESP with fault 01 and no bus strobe.
- BUS state:
  - read or write is held high, and address/byteenable/writedata are held stable, while waitrequest = 1.
  - When waitrequest = 0, loads register the formatted result and the unit goes to RESP.
- Byteenable:
  - SB: bit k.
  - SH: bits k, k+1.
  - SW, LW, LWL, LWR: the four lanes of the 32-bit word selected by k[OFS_W-1:2].
  - Loads enable only the lanes they consume.
- Writedata: byte replicated BYTES times; halfword replicated BYTES/2 times; word replicated BYTES/4 times.
- Load formatting: select the 32-bit word, then the halfword by k[1], then the byte by k[0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- LWL/LWR, with m = selected word and j = k[1:0]:
  - LWL = (m << 8(3-j)) | (rt_old & low (3-j) bytes).
  - LWR = (m >> 8j) | (rt_old & high j bytes).
- Timeout (TIMEOUT > 0):
  - A counter increments on every BUS cycle with waitrequest = 1.
  - On the TIMEOUT-th such cycle the next state is RESP with fault 10 and rdata 0.
  - The counter clears on entry to BUS.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.

## Timing
- The request is accepted at edge N. read/write are high from cycle N+1.
- With zero wait states, resp_valid is high in cycle N+2. Each waitrequest-high cycle adds one cycle.
- A misaligned request has resp_valid in cycle N+1.
- Minimum issue interval is 3 cycles; req_ready is low in BUS and RESP, and requests presented then are ignored.
- resp_rdata and resp_fault are valid only while resp_valid is high and hold their value until the next accept.
- Reset values: IDLE; req_ready 1; resp_valid, read, write 0; address, writedata, byteenable, resp_rdata, resp_fault 0; counter 0.
- Reset asserted mid-BUS drops read/write asynchronously. The transaction is lost and no resp_valid is produced.
- The Avalon outputs are registered, with no combinational path from req_* to the bus.

## Structure
- Package mips_lsu_pkg holds lsu_op_t, lsu_fault_t, lsu_state_t, and the is_load/is_store/access-size helper functions.
- Sub-module mips_lsu_align is combinational. Inputs: op, k, readdata word, rt_old. Outputs: byteenable, writedata, formatted load result, misalign flag.
- The top level holds the FSM, capture registers and timeout counter.

## Test plan
- SB, addr 0x1003, wdata 0x000000AB, waitrequest high for 3 cycles → address 0x1000, byteenable 1000, writedata 0xABABABAB, all held stable 4 cycles; resp_valid 1 cycle later; fault 00.
- LB then LBU, addr 0x2002, readdata 0x12F45678 → rdata 0xFFFFFFF4 then 0x000000F4; LH 0x2002 → 0x000012F4.
- LH addr 0x2001 → no read strobe, resp_valid at N+1, fault 01, rdata 0; SW addr 0x2002 → fault 01, no write.
- readdata 0xAABBCCDD, rt_old 0x11223344, addr 0x3001: LWL → 0xCCDD3344; LWR → 0x11AABBCC; LWL addr 0x3003 → 0xAABBCCDD.
- DATA_W = 64, LW addr 0x4004, readdata 0x89ABCDEF01234567 → address 0x4000, byteenable 0xF0, rdata 0x89ABCDEF; SH addr 0x4006, wdata 0xBEEF → byteenable 0xC0, writedata 0xBEEF repeated 4 times.
- TIMEOUT = 4, waitrequest held high → read high exactly 4 cycles, then resp fault 10. Reset pulsed low in a second BUS state → read 0 immediately, no resp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: shared types and op-decoding helpers for the MIPS load/store unit.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW
    } lsu_op_t;

    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_TIMEOUT  = 2'b10
    } lsu_fault_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    function automatic logic is_load(lsu_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic is_store(lsu_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic lsu_size_t op_size(lsu_op_t op);
        return op inside {OP_LB, OP_LBU, OP_SB} ? SZ_B :
               op inside {OP_LH, OP_LHU, OP_SH} ? SZ_H : SZ_W;
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: combinational lane steering, store replication, load formatting
// and alignment check for one LSU access.
module mips_lsu_align
    import mips_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFS_W = $clog2(BYTES)
) (
    input  lsu_op_t           op,
    input  logic [OFS_W-1:0]  k,
    input  logic [31:0]       wdata,
    input  logic [DATA_W-1:0] readdata,
    input  logic [31:0]       rt_old,
    output logic [BYTES-1:0]  byteenable,
    output logic [DATA_W-1:0] writedata,
    output logic [31:0]       rdata,
    output logic              misalign
);

    lsu_size_t        sz;
    logic [OFS_W-1:0] wsel;
    logic [31:0]      m;
    logic [15:0]      h;
    logic [7:0]       b;
    logic [1:0]       j;
    logic [3:0]       mask;
    logic [4:0]       lsh;
    logic [4:0]       rsh;

    always_comb begin
        sz   = op_size(op);
        wsel = k >> 2;
        m    = 32'(readdata >> {wsel, 5'b0});
        h    = k[1] ? m[31:16] : m[15:0];
        b    = k[0] ? h[15:8] : h[7:0];
        j    = k[1:0];
        lsh  = {2'd3 - j, 3'b0};
        rsh  = {j, 3'b0};
        mask = sz == SZ_B ? 4'h1 : sz == SZ_H ? 4'h3 : 4'hF;
        byteenable = BYTES'(mask) << (sz == SZ_W ? {wsel, 2'b00} : {2'b00, k});
        writedata  = sz == SZ_B ? {BYTES{wdata[7:0]}} :
                     sz == SZ_H ? {(BYTES/2){wdata[15:0]}} : {(BYTES/4){wdata}};
        // LWL/LWR keep exactly the rt bytes the shifted memory word does not cover
        case (op)
            OP_LB:   rdata = {{24{b[7]}}, b};
            OP_LBU:  rdata = {24'b0, b};
            OP_LH:   rdata = {{16{h[15]}}, h};
            OP_LHU:  rdata = {16'b0, h};
            OP_LW:   rdata = m;
            OP_LWL:  rdata = (m << lsh) | (rt_old & ~(32'hFFFF_FFFF << lsh));
            OP_LWR:  rdata = (m >> rsh) | (rt_old & ~(32'hFFFF_FFFF >> rsh));
            default: rdata = 32'b0;
        endcase
        misalign = (op inside {OP_LH, OP_LHU, OP_SH} && k[0]) ||
                   (op inside {OP_LW, OP_SW} && k[1:0] != 2'b00);
    end

endmodule

// File: rtl/mips_lsu_bus.sv
// mips_lsu_bus: single-outstanding MIPS load/store unit driving an Avalon-MM data master
// with registered bus outputs, misalignment and optional waitrequest timeout faults.
module mips_lsu_bus
    import mips_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFS_W  = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  lsu_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt_old,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output lsu_fault_t        resp_fault,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [DATA_W-1:0] writedata,
    output logic [BYTES-1:0]  byteenable,
    input  logic [DATA_W-1:0] readdata
);

    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic [OFS_W-1:0]  k_q, k_d;
    logic [31:0]       rt_q, rt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d, write_q, write_d;
    logic [BYTES-1:0]  be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [31:0]       rdata_q, rdata_d;
    lsu_fault_t        fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    lsu_op_t           al_op;
    logic [OFS_W-1:0]  al_k;
    logic [31:0]       al_rt, al_rdata;
    logic [BYTES-1:0]  al_be;
    logic [DATA_W-1:0] al_wd;
    logic              al_mis, idle, timed_out;

    // In IDLE the aligner sees the incoming request; afterwards it formats readdata
    assign idle      = state_q == ST_IDLE;
    assign al_op     = idle ? req_op : op_q;
    assign al_k      = idle ? req_addr[OFS_W-1:0] : k_q;
    assign al_rt     = idle ? req_rt_old : rt_q;
    assign timed_out = TIMEOUT > 0 && waitrequest && cnt_q == CNT_MAX;

    mips_lsu_align #(.DATA_W(DATA_W)) u_align (
        .op         (al_op),
        .k          (al_k),
        .wdata      (req_wdata),
        .readdata   (readdata),
        .rt_old     (al_rt),
        .byteenable (al_be),
        .writedata  (al_wd),
        .rdata      (al_rdata),
        .misalign   (al_mis)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        rt_d    = rt_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                op_d    = req_op;
                k_d     = req_addr[OFS_W-1:0];
                rt_d    = req_rt_old;
                rdata_d = 32'b0;
                cnt_d   = '0;
                fault_d = al_mis ? FLT_MISALIGN : FLT_OK;
                state_d = al_mis ? ST_RESP : ST_BUS;
                if (!al_mis) begin
                    addr_d  = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                    read_d  = is_load(req_op);
                    write_d = is_store(req_op);
                    be_d    = al_be;
                    wd_d    = al_wd;
                end
            end
            ST_BUS: if (!waitrequest || timed_out) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                rdata_d = !waitrequest && read_q ? al_rdata : 32'b0;
                fault_d = waitrequest ? FLT_TIMEOUT : FLT_OK;
                state_d = ST_RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LB;
            k_q     <= '0;
            rt_q    <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            be_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            fault_q <= FLT_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            rt_q    <= rt_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = idle;
    assign resp_valid = state_q == ST_RESP;
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign address    = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = be_q;
    assign writedata  = wd_q;

endmodule

// File: tb/tb_mips_lsu_bus.sv
// tb_mips_lsu_bus: directed vector bench for a 32-bit untimed and a 64-bit TIMEOUT=4 LSU.
module tb_mips_lsu_bus;
    import mips_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid32, valid64, waitrequest, use64;
    lsu_op_t     req_op;
    logic [31:0] req_addr, req_wdata, req_rt_old;
    logic [63:0] readdata;

    logic        rdy32, rv32, rd32, wr32, rdy64, rv64, rd64, wr64;
    logic [31:0] rdata32, addr32, wd32, rdata64, addr64;
    logic [3:0]  be32;
    logic [7:0]  be64;
    logic [63:0] wd64;
    lsu_fault_t  f32, f64;

    logic        s_ready, s_rv, s_read, s_write;
    logic [31:0] s_addr, s_rdata;
    logic [7:0]  s_be;
    logic [63:0] s_wd;
    logic [1:0]  s_fault;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mips_lsu_bus #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(0)) d32 (
        .clk(clk), .reset(reset), .req_valid(valid32), .req_ready(rdy32), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .resp_valid(rv32), .resp_rdata(rdata32), .resp_fault(f32), .address(addr32),
        .read(rd32), .write(wr32), .waitrequest(waitrequest), .writedata(wd32),
        .byteenable(be32), .readdata(readdata[31:0])
    );

    mips_lsu_bus #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) d64 (
        .clk(clk), .reset(reset), .req_valid(valid64), .req_ready(rdy64), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .resp_valid(rv64), .resp_rdata(rdata64), .resp_fault(f64), .address(addr64),
        .read(rd64), .write(wr64), .waitrequest(waitrequest), .writedata(wd64),
        .byteenable(be64), .readdata(readdata)
    );

    assign s_ready = use64 ? rdy64 : rdy32;
    assign s_rv    = use64 ? rv64 : rv32;
    assign s_read  = use64 ? rd64 : rd32;
    assign s_write = use64 ? wr64 : wr32;
    assign s_addr  = use64 ? addr64 : addr32;
    assign s_rdata = use64 ? rdata64 : rdata32;
    assign s_be    = use64 ? be64 : {4'b0, be32};
    assign s_wd    = use64 ? wd64 : {32'b0, wd32};
    assign s_fault = use64 ? f64 : f32;

    typedef struct {
        logic       w64;
        lsu_op_t    op;
        logic [31:0] addr, wdata, rt;
        logic [63:0] rd;
        int         waits;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wd;
        logic [31:0] e_rdata;
        lsu_fault_t e_fault;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int i);
        vec_t v = vecs[i];
        logic ok = 1'b1;
        logic st = v.op inside {OP_SB, OP_SH, OP_SW};
        use64 = v.w64;
        req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_rt_old = v.rt;
        readdata = v.rd;
        waitrequest = v.waits != 0;
        if (v.w64) valid64 = 1'b1; else valid32 = 1'b1;
        step();
        valid32 = 1'b0; valid64 = 1'b0;
        if (v.e_fault == FLT_MISALIGN) begin
            chk($sformatf("v%0d_mis_valid", i), 64'(s_rv), 64'd1);
            chk($sformatf("v%0d_mis_strobe", i), 64'({s_read, s_write}), 64'd0);
            chk($sformatf("v%0d_mis_fault", i), 64'(s_fault), 64'(FLT_MISALIGN));
            chk($sformatf("v%0d_mis_rdata", i), 64'(s_rdata), 64'd0);
            step();
            chk($sformatf("v%0d_mis_ready", i), 64'({s_ready, s_rv}), 64'b10);
        end else begin
            chk($sformatf("v%0d_addr", i), 64'(s_addr), 64'(v.e_addr));
            chk($sformatf("v%0d_be", i), 64'(s_be), 64'(v.e_be));
            chk($sformatf("v%0d_wd", i), s_wd, v.e_wd);
            for (int c = 0; c <= v.waits; c++) begin
                waitrequest = c < v.waits;
                ok &= s_addr == v.e_addr && s_be == v.e_be && s_wd == v.e_wd &&
                      s_read == !st && s_write == st && !s_rv && !s_ready;
                step();
            end
            chk($sformatf("v%0d_bus_hold", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_resp", i), 64'({s_rv, s_read, s_write}), 64'b100);
            chk($sformatf("v%0d_rdata", i), 64'(s_rdata), 64'(v.e_rdata));
            chk($sformatf("v%0d_fault", i), 64'(s_fault), 64'(v.e_fault));
            step();
            chk($sformatf("v%0d_idle", i), 64'({s_ready, s_rv}), 64'b10);
        end
        waitrequest = 1'b0;
    endtask

    initial begin
        int nread, nwrite;
        logic got, seen;
        vecs[0]  = '{0, OP_SB,  32'h1003, 32'h0000_00AB, 0, 0, 3, 32'h1000, 8'h08, 64'hABAB_ABAB, 0, FLT_OK};
        vecs[1]  = '{0, OP_LB,  32'h2002, 0, 0, 64'h12F4_5678, 0, 32'h2000, 8'h04, 0, 32'hFFFF_FFF4, FLT_OK};
        vecs[2]  = '{0, OP_LBU, 32'h2002, 0, 0, 64'h12F4_5678, 1, 32'h2000, 8'h04, 0, 32'h0000_00F4, FLT_OK};
        vecs[3]  = '{0, OP_LH,  32'h2002, 0, 0, 64'h12F4_5678, 0, 32'h2000, 8'h0C, 0, 32'h0000_12F4, FLT_OK};
        vecs[4]  = '{0, OP_LH,  32'h2001, 0, 0, 64'h12F4_5678, 0, 0, 0, 0, 0, FLT_MISALIGN};
        vecs[5]  = '{0, OP_SW,  32'h2002, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, FLT_MISALIGN};
        vecs[6]  = '{0, OP_LWL, 32'h3001, 0, 32'h1122_3344, 64'hAABB_CCDD, 0, 32'h3000, 8'h0F, 0, 32'hCCDD_3344, FLT_OK};
        vecs[7]  = '{0, OP_LWR, 32'h3001, 0, 32'h1122_3344, 64'hAABB_CCDD, 0, 32'h3000, 8'h0F, 0, 32'h11AA_BBCC, FLT_OK};
        vecs[8]  = '{0, OP_LWL, 32'h3003, 0, 32'h1122_3344, 64'hAABB_CCDD, 2, 32'h3000, 8'h0F, 0, 32'hAABB_CCDD, FLT_OK};
        vecs[9]  = '{0, OP_SH,  32'h2006, 32'h0000_BEEF, 0, 0, 1, 32'h2004, 8'h0C, 64'hBEEF_BEEF, 0, FLT_OK};
        vecs[10] = '{0, OP_LHU, 32'h2006, 0, 0, 64'h8001_0000, 0, 32'h2004, 8'h0C, 0, 32'h0000_8001, FLT_OK};
        vecs[11] = '{0, OP_LH,  32'h2006, 0, 0, 64'h8001_0000, 0, 32'h2004, 8'h0C, 0, 32'hFFFF_8001, FLT_OK};
        vecs[12] = '{0, OP_SW,  32'h2008, 32'hDEAD_BEEF, 0, 0, 0, 32'h2008, 8'h0F, 64'hDEAD_BEEF, 0, FLT_OK};
        vecs[13] = '{1, OP_LW,  32'h4004, 0, 0, 64'h89AB_CDEF_0123_4567, 0, 32'h4000, 8'hF0, 0, 32'h89AB_CDEF, FLT_OK};
        vecs[14] = '{1, OP_SH,  32'h4006, 32'h0000_BEEF, 0, 0, 2, 32'h4000, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 0, FLT_OK};
        vecs[15] = '{1, OP_LB,  32'h4007, 0, 0, 64'h89AB_CDEF_0123_4567, 1, 32'h4000, 8'h80, 0, 32'hFFFF_FF89, FLT_OK};
        vecs[16] = '{1, OP_LWR, 32'h4005, 0, 32'h1122_3344, 64'h89AB_CDEF_0123_4567, 0, 32'h4000, 8'hF0, 0, 32'h1189_ABCD, FLT_OK};
        vecs[17] = '{1, OP_SB,  32'h4000, 32'h0000_005A, 0, 0, 3, 32'h4000, 8'h01, 64'h5A5A_5A5A_5A5A_5A5A, 0, FLT_OK};

        reset = 1'b0; valid32 = 1'b0; valid64 = 1'b0; waitrequest = 1'b0; use64 = 1'b0;
        req_op = OP_LB; req_addr = 0; req_wdata = 0; req_rt_old = 0; readdata = 0;
        step();
        step();
        chk("rst_ctrl", 64'({s_ready, s_rv, s_read, s_write}), 64'b1000);
        chk("rst_bus", {s_addr, s_be, 24'b0}, 64'd0);
        chk("rst_wd", s_wd, 64'd0);
        chk("rst_resp", 64'({s_rdata, s_fault}), 64'd0);
        reset = 1'b1;
        step();
        chk("post_rst_ready", 64'({rdy32, rdy64, rv32, rv64}), 64'b1100);

        for (int i = 0; i < 18; i++) run(i);

        // timeout with a request presented (and ignored) while busy
        use64 = 1'b1;
        req_op = OP_LW; req_addr = 32'h4000; waitrequest = 1'b1; valid64 = 1'b1;
        step();
        req_op = OP_SW; req_addr = 32'h5000;
        nread = 0; nwrite = 0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            nread += int'(s_read);
            nwrite += int'(s_write);
            if (s_rv) begin
                got = 1'b1;
                chk("to_fault", 64'(s_fault), 64'(FLT_TIMEOUT));
                chk("to_rdata", 64'(s_rdata), 64'd0);
            end
            step();
            valid64 = 1'b0;
        end
        chk("to_resp_seen", 64'(got), 64'd1);
        chk("to_read_cycles", 64'(nread), 64'd4);
        chk("to_no_write", 64'(nwrite), 64'd0);
        chk("to_addr_kept", 64'(s_addr), 64'h4000);
        chk("to_idle", 64'({s_ready, s_rv}), 64'b10);

        // asynchronous reset in the middle of a bus cycle
        req_op = OP_LW; req_addr = 32'h4008; valid64 = 1'b1;
        step();
        valid64 = 1'b0;
        chk("rst_mid_read_pre", 64'({s_read, s_ready}), 64'b10);
        #2 reset = 1'b0;
        #1 chk("rst_mid_read_drop", 64'({s_read, s_ready}), 64'b01);
        #3 reset = 1'b1;
        waitrequest = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            seen |= s_rv | s_read;
        end
        chk("rst_mid_no_resp", 64'(seen), 64'd0);
        chk("rst_mid_ready", 64'(s_ready), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
